div_clk_monitor: RTL

DIV_CLK_MONITOR -- requirements
Module: div_clk_monitor

---
 rtl/div_clk_monitor.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/div_clk_monitor.sv
// div_clk_monitor: measures high/low phase lengths of a sys_clk-synchronous
// divided clock, counts periods, tracks lock against the expected shape and
// raises a sticky error on loss of lock or counter overflow.
module div_clk_monitor #(
  parameter int unsigned EXP_HIGH = 3,
  parameter int unsigned EXP_LOW  = 4,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             clk_div_in,
  input  logic             err_clr,
  output logic             rise_pulse,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic [15:0]      period_cnt
);

  localparam int unsigned      GW       = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] EXP_H    = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] EXP_L    = CNT_W'(EXP_LOW);
  localparam logic [GW-1:0]    LOCK_MAX = GW'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  state_t           state;
  logic             d1;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] lcnt;
  logic [GW-1:0]    good_cnt;

  logic             rise;
  logic             fall;
  logic             period_end;
  logic             period_good;
  logic             ovf;
  logic             err_set;
  logic [GW-1:0]    good_nxt;

  // Edge detection, period evaluation and error-set conditions.
  always_comb begin
    rise        = clk_div_in & ~d1;
    fall        = ~clk_div_in & d1;
    period_end  = (state == LOW) && rise;
    period_good = (high_len == EXP_H) && (lcnt == EXP_L);
    ovf         = ((state == HIGH) && clk_div_in && (hcnt == CNT_MAX)) ||
                  ((state == LOW) && !clk_div_in && (lcnt == CNT_MAX));
    err_set     = ovf || (period_end && !period_good && locked);
    good_nxt    = '0;
    if (period_good) begin
      good_nxt = (good_cnt == LOCK_MAX) ? good_cnt : good_cnt + GW'(1);
    end
  end

  // Input delay register and rise pulse, independent of FSM state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      d1         <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      d1         <= clk_div_in;
      rise_pulse <= rise;
    end
  end

  // Phase-measurement FSM with period, length and lock outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      hcnt         <= '0;
      lcnt         <= '0;
      high_len     <= '0;
      low_len      <= '0;
      period_valid <= 1'b0;
      period_cnt   <= '0;
      good_cnt     <= '0;
      locked       <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        IDLE: begin
          hcnt <= '0;
          lcnt <= '0;
          if (rise) begin
            state <= HIGH;
            hcnt  <= CNT_ONE;
          end
        end
        HIGH: begin
          if (fall) begin
            state    <= LOW;
            high_len <= hcnt;
            lcnt     <= CNT_ONE;
          end else if (clk_div_in) begin
            // Overflow leaves hcnt saturated; IDLE zeroes it next cycle.
            if (hcnt == CNT_MAX) begin
              state    <= IDLE;
              good_cnt <= '0;
              locked   <= 1'b0;
            end else begin
              hcnt <= hcnt + CNT_ONE;
            end
          end
        end
        LOW: begin
          if (rise) begin
            state        <= HIGH;
            hcnt         <= CNT_ONE;
            low_len      <= lcnt;
            period_valid <= 1'b1;
            period_cnt   <= period_cnt + 16'd1;
            good_cnt     <= good_nxt;
            locked       <= (good_nxt == LOCK_MAX);
          end else if (!clk_div_in) begin
            if (lcnt == CNT_MAX) begin
              state    <= IDLE;
              good_cnt <= '0;
              locked   <= 1'b0;
            end else begin
              lcnt <= lcnt + CNT_ONE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Sticky error flag; a set in the same cycle as a clear wins.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule
